gray_conv_arbiter: RTL and testbench
====================================

Name: gray_conv_arbiter

Overview:
- Shares one binary/gray code converter between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- Each request carries a W-bit operand and a direction bit: binary-to-gray or gray-to-binary.
- The result is registered once and tagged with the requester ID.
- Sits between the counter/pointer blocks that need code conversion and the single shared converter datapath.

Parameters:
- W, 4, operand/result width in bits (>= 2).
- NUM_REQ, 4, number of requesters; fixed at 4 for this revision (ID is 2 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i high = requester i presents an operand.
- req_data  input  NUM_REQ*W  requester i operand on bits [i*W +: W].
- req_mode  input  NUM_REQ  bit i: 0 = binary->gray, 1 = gray->binary.
- req_ready  output  NUM_REQ  one-hot grant; bit i high = requester i's operand is accepted this cycle.
- res_valid  output  1  result register holds a valid result.
- res_data  output  W  converted value.
- res_id  output  2  index of the requester that owns res_data.
- res_mode  output  1  direction used for res_data.
- res_ready  input  1  downstream consumer accepts the result this cycle.
- busy  output  1  equals res_valid; status only.

Behaviour:
- Reset (asynchronous, any time):
  - res_valid=0, res_data=0, res_id=0, res_mode=0.
  - Round-robin pointer last_grant=3, so requester 0 has top priority after reset.
  - Any in-flight result is discarded.
  - req_ready is 0 while rst is high.
- Slot free condition: slot_free = !res_valid | res_ready.
- Grant (combinational):
  - When slot_free and |req_valid, grant the first requester with req_valid set, searching from (last_grant+1) mod 4 upward with wrap.
  - req_ready is exactly that one-hot grant; otherwise req_ready = 0.
  - At most one bit of req_ready is high per cycle.
  - req_ready never depends on req_data or req_mode.
- Transfer on the clock edge with grant g:
  - res_valid<=1, res_id<=g, res_mode<=req_mode[g], last_grant<=g.
  - res_data<=conv(req_data[g], req_mode[g]).
  - Latency from grant to result visible is 1 cycle.
- Consume without a new grant (res_valid & res_ready & no req_valid): res_valid<=0. res_data, res_id and res_mode hold their last values.
- Simultaneous consume and grant: the register is reloaded in the same edge, so res_valid stays 1. Back-to-back throughput is 1 result per cycle.
- Backpressure (res_valid & !res_ready): res_* hold stable, req_ready=0, last_grant unchanged.
- Requester protocol: a requester holds valid, data and mode stable until it sees req_ready. The arbiter does not buffer unaccepted requests.
- Conversion, b = binary operand, g = gray operand:
  - Binary->gray: out[W-1]=b[W-1]; out[k]=b[k+1]^b[k].
  - Gray->binary: out[W-1]=g[W-1]; out[k]=out[k+1]^g[k], for k = W-2 down to 0.
  - No width growth; purely bitwise.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,2,3,0,... and no requester waits more than 3 grants.
- A requester that drops req_valid is skipped without losing a cycle.
- busy mirrors res_valid.

Test Plan:
1. Reset, then req_valid=0001, req_data[3:0]=0011, mode=0, res_ready=1 -> req_ready=0001 in that cycle; next cycle res_valid=1, res_data=0010, res_id=0.
2. Single requester 2: data 1111 mode 0 -> res_data 1000. Then data 1000 mode 1 -> res_data 1111, res_mode=1. Also check 0100 mode 0 -> 0110.
3. All four valid continuously, res_ready=1, distinct operands -> res_id sequence 0,1,2,3,0,1 on consecutive cycles, each res_data matching its requester's operand.
4. Backpressure: result pending, res_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 and res_* stable. Raising res_ready gives the next grant to last_grant+1 in that same cycle.
5. Sparse requests: req_valid=1010 after last_grant=1 -> grant 3, then 1. Valid drops to 0 with res_ready=1 -> res_valid falls to 0 next cycle.
6. Assert rst mid-stream between clock edges while res_valid=1 -> res_valid=0 immediately (asynchronous). After release, first grant goes to requester 0 with req_valid=1111.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
//
// Shares one binary<->gray converter between NUM_REQ requesters. A round-robin
// arbiter picks one valid requester per cycle when the result register is
// free (empty, or being consumed this cycle). The chosen operand is converted
// and captured in a single result register tagged with the requester index
// and conversion direction.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  [NUM_REQ]    requester i presents an operand
//   req_data   [NUM_REQ*W]  requester i operand on bits [i*W +: W]
//   req_mode   [NUM_REQ]    0 = binary->gray, 1 = gray->binary
//   req_ready  [NUM_REQ]    one-hot grant, requester i accepted this cycle
//   res_valid  result register holds a valid result
//   res_data   [W]          converted value
//   res_id     [2]          requester that owns res_data
//   res_mode   direction used for res_data
//   res_ready  downstream accepts the result this cycle
//   busy       mirrors res_valid
// -----------------------------------------------------------------------------
module gray_conv_arbiter #(
   parameter int W       = 4,
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*W-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_mode,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 res_valid,
   output logic [W-1:0]         res_data,
   output logic [1:0]           res_id,
   output logic                 res_mode,
   input  logic                 res_ready,
   output logic                 busy
);

   logic         res_valid_reg;
   logic [W-1:0] res_data_reg;
   logic [1:0]   res_id_reg;
   logic         res_mode_reg;
   logic [1:0]   last_grant_reg;

   // Per-requester converted value, computed in parallel; the grant index
   // then selects one of them.
   logic [W-1:0] conv_data [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_conv
      logic [W-1:0] operand;
      logic [W-1:0] b2g;
      logic [W-1:0] g2b;

      assign operand = req_data[gi*W +: W];
      assign b2g     = operand ^ (operand >> 1);

      // Binary bit k is the XOR of all gray bits from k up to the MSB;
      // written as a reduction so there is no bit-to-bit feedback chain.
      for (genvar bi = 0; bi < W; bi++) begin : g_bit
         assign g2b[bi] = ^(operand >> bi);
      end

      assign conv_data[gi] = req_mode[gi] ? g2b : b2g;
   end

   // Round-robin grant: search from last_grant+1 upward with wrap.
   logic             slot_free;
   logic             grant_any;
   logic [1:0]       grant_idx;
   logic [1:0]       cand;
   logic [NUM_REQ-1:0] grant_onehot;

   always_comb begin
      slot_free    = !res_valid_reg || res_ready;
      grant_any    = 1'b0;
      grant_idx    = 2'd0;
      cand         = 2'd0;
      grant_onehot = '0;
      if (slot_free && !rst) begin
         for (int off = 1; off <= NUM_REQ; off++) begin
            cand = last_grant_reg + 2'(off);
            if (!grant_any && req_valid[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (grant_any) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

   assign req_ready = grant_onehot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_reg  <= 1'b0;
         res_data_reg   <= '0;
         res_id_reg     <= 2'd0;
         res_mode_reg   <= 1'b0;
         last_grant_reg <= 2'd3;
      end else if (grant_any) begin
         // Covers both "slot empty" and "consume + reload in the same edge".
         res_valid_reg  <= 1'b1;
         res_data_reg   <= conv_data[grant_idx];
         res_id_reg     <= grant_idx;
         res_mode_reg   <= req_mode[grant_idx];
         last_grant_reg <= grant_idx;
      end else if (res_ready) begin
         // Consumed with nothing to reload: payload fields keep their values.
         res_valid_reg  <= 1'b0;
      end
   end

   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_id    = res_id_reg;
   assign res_mode  = res_mode_reg;
   assign busy      = res_valid_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
//
// Directed testbench for gray_conv_arbiter (W=4, NUM_REQ=4). Inputs change on
// the falling edge; req_ready is sampled 1 time unit later and registered
// results 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;

   localparam int W = 4;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_mode;
   logic [N-1:0]   req_ready;
   logic           res_valid;
   logic [W-1:0]   res_data;
   logic [1:0]     res_id;
   logic           res_mode;
   logic           res_ready;
   logic           busy;

   int checks = 0;
   int errors = 0;

   gray_conv_arbiter #(.W(W), .NUM_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_mode  (req_mode),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_mode  (res_mode),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Stimulus driver only: applies inputs on the falling edge.
   task automatic drive(input logic [3:0] v, input logic [15:0] d,
                        input logic [3:0] m, input logic r);
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      req_mode  = m;
      res_ready = r;
      #1;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = 16'h1234;
      req_mode  = 4'b0000;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
      end
      checks++;
      if ({res_valid, res_data, res_id, res_mode, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b data=%b id=%0d mode=%b busy=%b exp all 0",
                  res_valid, res_data, res_id, res_mode, busy);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      rst       = 1'b0;
   endtask

   task automatic test_basic;
      drive(4'b0001, 16'h0003, 4'b0000, 1'b1);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL basic_grant got=%b exp=0001", req_ready);
      end
      @(posedge clk); #1;
      $display("txn basic: id=%0d mode=%b data=%b valid=%b", res_id, res_mode, res_data, res_valid);
      checks++;
      if ({res_valid, busy, res_data, res_id} !== {1'b1, 1'b1, 4'b0010, 2'd0}) begin
         errors++;
         $display("FAIL basic_result got valid=%b busy=%b data=%b id=%0d exp valid=1 busy=1 data=0010 id=0",
                  res_valid, busy, res_data, res_id);
      end
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   task automatic test_single_req2;
      logic [3:0] din  [3];
      logic       mdin [3];
      logic [3:0] dexp [3];
      din[0] = 4'b1111; mdin[0] = 1'b0; dexp[0] = 4'b1000;
      din[1] = 4'b1000; mdin[1] = 1'b1; dexp[1] = 4'b1111;
      din[2] = 4'b0100; mdin[2] = 1'b0; dexp[2] = 4'b0110;
      for (int t = 0; t < 3; t++) begin
         drive(4'b0100, {4'h0, din[t], 8'h00}, {1'b0, mdin[t], 2'b00}, 1'b1);
         checks++;
         if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL req2_grant[%0d] got=%b exp=0100", t, req_ready);
         end
         @(posedge clk); #1;
         $display("txn req2[%0d]: id=%0d mode=%b in=%b out=%b", t, res_id, res_mode, din[t], res_data);
         checks++;
         if ({res_valid, res_data, res_id, res_mode} !== {1'b1, dexp[t], 2'd2, mdin[t]}) begin
            errors++;
            $display("FAIL req2_result[%0d] got valid=%b data=%b id=%0d mode=%b exp valid=1 data=%b id=2 mode=%b",
                     t, res_valid, res_data, res_id, res_mode, dexp[t], mdin[t]);
         end
      end
      drive(4'b0000, 16'h0000, 4'b0000, 1'b1);
   endtask

   // Operands r3..r0 = 1101,1011,0110,0001; modes r3..r0 = 1,0,1,0.
   // Expected results: r0 0001, r1 0100, r2 1110, r3 1001.
   task automatic test_round_robin;
      logic [3:0] dexp [4];
      logic [1:0] id_exp;
      dexp[0] = 4'b0001; dexp[1] = 4'b0100; dexp[2] = 4'b1110; dexp[3] = 4'b1001;
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      drive(4'b1111, 16'hDB61, 4'b1010, 1'b1);
      for (int t = 0; t < 6; t++) begin
         id_exp = 2'(t % 4);
         if (t != 0) begin
            @(negedge clk); #1;
         end
         checks++;
         if (req_ready !== (4'b0001 << id_exp)) begin
            errors++;
            $display("FAIL rr_grant[%0d] got=%b exp=%b", t, req_ready, 4'b0001 << id_exp);
         end
         @(posedge clk); #1;
         $display("txn rr[%0d]: id=%0d mode=%b data=%b", t, res_id, res_mode, res_data);
         checks++;
         if ({res_valid, res_id, res_data, res_mode} !== {1'b1, id_exp, dexp[id_exp], id_exp[0]}) begin
            errors++;
            $display("FAIL rr_result[%0d] got valid=%b id=%0d data=%b mode=%b exp valid=1 id=%0d data=%b mode=%b",
                     t, res_valid, res_id, res_data, res_mode, id_exp, dexp[id_exp], id_exp[0]);
         end
      end
   endtask

   // Entered with result id=1 (data 0100) pending and last grant 1.
   task automatic test_backpressure;
      drive(4'b1111, 16'hDB61, 4'b1010, 1'b0);
      for (int t = 0; t < 3; t++) begin
         if (t != 0) begin
            @(negedge clk); #1;
         end
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready[%0d] got=%b exp=0000", t, req_ready);
         end
         checks++;
         if ({res_valid, res_id, res_data, res_mode} !== {1'b1, 2'd1, 4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b id=%0d data=%b mode=%b exp valid=1 id=1 data=0100 mode=1",
                     t, res_valid, res_id, res_data, res_mode);
         end
      end
      drive(4'b1111, 16'hDB61, 4'b1010, 1'b1);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL bp_release_grant got=%b exp=0100", req_ready);
      end
      @(posedge clk); #1;
      $display("txn bp_release: id=%0d data=%b", res_id, res_data);
      checks++;
      if ({res_valid, res_id, res_data} !== {1'b1, 2'd2, 4'b1110}) begin
         errors++;
         $display("FAIL bp_release_result got valid=%b id=%0d data=%b exp valid=1 id=2 data=1110",
                  res_valid, res_id, res_data);
      end
   endtask

   task automatic test_sparse;
      // Bring last grant to 1.
      drive(4'b0010, 16'hDB61, 4'b1010, 1'b1);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL sparse_setup_grant got=%b exp=0010", req_ready);
      end
      @(posedge clk);
      drive(4'b1010, 16'hDB61, 4'b1010, 1'b1);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL sparse_grant3 got=%b exp=1000", req_ready);
      end
      @(posedge clk); #1;
      $display("txn sparse_a: id=%0d data=%b", res_id, res_data);
      checks++;
      if ({res_id, res_data, res_mode} !== {2'd3, 4'b1001, 1'b1}) begin
         errors++;
         $display("FAIL sparse_result3 got id=%0d data=%b mode=%b exp id=3 data=1001 mode=1",
                  res_id, res_data, res_mode);
      end
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL sparse_grant1 got=%b exp=0010", req_ready);
      end
      @(posedge clk); #1;
      $display("txn sparse_b: id=%0d data=%b", res_id, res_data);
      checks++;
      if ({res_id, res_data} !== {2'd1, 4'b0100}) begin
         errors++;
         $display("FAIL sparse_result1 got id=%0d data=%b exp id=1 data=0100", res_id, res_data);
      end
      drive(4'b0000, 16'hDB61, 4'b1010, 1'b1);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL sparse_idle_ready got=%b exp=0000", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid, busy, res_id, res_data} !== {1'b0, 1'b0, 2'd1, 4'b0100}) begin
         errors++;
         $display("FAIL sparse_drain got valid=%b busy=%b id=%0d data=%b exp valid=0 busy=0 id=1 data=0100",
                  res_valid, busy, res_id, res_data);
      end
   endtask

   task automatic test_async_reset;
      drive(4'b1000, 16'hDB61, 4'b1010, 1'b1);
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_id} !== {1'b1, 2'd3}) begin
         errors++;
         $display("FAIL areset_setup got valid=%b id=%0d exp valid=1 id=3", res_valid, res_id);
      end
      #1;
      rst       = 1'b1;
      req_valid = 4'b1111;
      #1;
      checks++;
      if ({res_valid, busy, res_data, res_id} !== 8'b0) begin
         errors++;
         $display("FAIL areset_clear got valid=%b busy=%b data=%b id=%0d exp all 0",
                  res_valid, busy, res_data, res_id);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL areset_ready got=%b exp=0000", req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL areset_first_grant got=%b exp=0001", req_ready);
      end
      @(posedge clk); #1;
      $display("txn after_reset: id=%0d data=%b", res_id, res_data);
      checks++;
      if ({res_valid, res_id, res_data} !== {1'b1, 2'd0, 4'b0001}) begin
         errors++;
         $display("FAIL areset_first_result got valid=%b id=%0d data=%b exp valid=1 id=0 data=0001",
                  res_valid, res_id, res_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_req2();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
